uart_tx_arbiter: RTL and testbench

//  Shares one 8N1 byte transmitter (start-pulse / busy interface) among N_REQ byte sources.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit after ptr, wrapping mod N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Scan ptr+1, ptr+2, .. ptr+N; the first hit wins, later hits are masked by 'any'.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s         = IDX_W'((int'(ptr) + k) % N);
            hit_s          = !any && req[cand_s];
            onehot[cand_s] = onehot[cand_s] | hit_s;
            idx            = hit_s ? cand_s : idx;
            any            = any | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one start/busy byte transmitter,
// with a watchdog on the transmitter's busy acknowledge.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ACK_TMO = 16
) (
    input  logic                         clkin,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             grant,
    output logic                         tx_start,
    output logic [UART_DATA_W-1:0]       tx_data,
    input  logic                         tx_busy,
    output logic                         err_tmo
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMO_W = $clog2(ACK_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

    arb_state_e             state_r,     state_nxt_s;
    logic [N_REQ-1:0]       grant_r,     grant_nxt_s;
    logic [IDX_W-1:0]       owner_r,     owner_nxt_s;
    logic [IDX_W-1:0]       rr_ptr_r,    rr_ptr_nxt_s;
    logic [TMO_W-1:0]       tmo_cnt_r,   tmo_cnt_nxt_s;
    logic [UART_DATA_W-1:0] tx_data_r,   tx_data_nxt_s;
    logic                   last_r,      last_nxt_s;
    logic [N_REQ-1:0]       req_ready_r, req_ready_nxt_s;
    logic                   tx_start_r,  tx_start_nxt_s;
    logic                   err_tmo_r,   err_tmo_nxt_s;

    logic [N_REQ-1:0]       pick_onehot_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_any_s;
    logic [UART_DATA_W-1:0] owner_byte_s;
    logic                   owner_valid_s;
    logic                   owner_last_s;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign owner_valid_s = req_valid[owner_r];
    assign owner_last_s  = req_last[owner_r];

    // Byte lane of the current owner.
    always_comb begin
        owner_byte_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            owner_byte_s = (owner_r == IDX_W'(i)) ? req_data[i*UART_DATA_W +: UART_DATA_W]
                                                  : owner_byte_s;
        end
    end

    // Next-state and registered-output decode; pulses default low every cycle.
    always_comb begin
        state_nxt_s     = state_r;
        grant_nxt_s     = grant_r;
        owner_nxt_s     = owner_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;
        tx_data_nxt_s   = tx_data_r;
        last_nxt_s      = last_r;
        req_ready_nxt_s = '0;
        tx_start_nxt_s  = 1'b0;
        err_tmo_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_nxt_s = pick_onehot_s;
                    owner_nxt_s = pick_idx_s;
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (owner_valid_s) begin
                    req_ready_nxt_s = grant_r;
                    tx_start_nxt_s  = 1'b1;
                    tx_data_nxt_s   = owner_byte_s;
                    last_nxt_s      = owner_last_s;
                    tmo_cnt_nxt_s   = '0;
                    state_nxt_s     = ST_WAIT_ACK;
                end else begin
                    // Owner walked away mid-message: release and demote it.
                    rr_ptr_nxt_s = owner_r;
                    grant_nxt_s  = '0;
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    err_tmo_nxt_s = 1'b1;
                    rr_ptr_nxt_s  = owner_r;
                    grant_nxt_s   = '0;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (tx_busy) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (last_r) begin
                    rr_ptr_nxt_s = owner_r;
                    grant_nxt_s  = '0;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                grant_nxt_s = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            owner_r     <= '0;
            rr_ptr_r    <= IDX_W'(N_REQ - 1);
            tmo_cnt_r   <= '0;
            tx_data_r   <= '0;
            last_r      <= 1'b0;
            req_ready_r <= '0;
            tx_start_r  <= 1'b0;
            err_tmo_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            owner_r     <= owner_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            last_r      <= last_nxt_s;
            req_ready_r <= req_ready_nxt_s;
            tx_start_r  <= tx_start_nxt_s;
            err_tmo_r   <= err_tmo_nxt_s;
        end
    end

    assign grant     = grant_r;
    assign req_ready = req_ready_r;
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign err_tmo   = err_tmo_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: producer queues, a 10-cycle busy transmitter model and a
// message-level round-robin reference that predicts the transmitted byte stream.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int TMO      = 16;
    localparam int BUSY_LEN = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           err_tmo;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .ACK_TMO(TMO)) dut (
        .clkin     (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .err_tmo   (err_tmo)
    );

    typedef struct {int src; logic [7:0] data;} exp_t;
    typedef struct {int src; logic [7:0] data; int exp_src; logic [7:0] exp_data;} vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [8:0] prod_q [N][$];   // {last, byte} per requester
    exp_t       exp_q [$];
    int         model_ptr = N - 1;
    int         busy_cnt = 0;
    bit         start_d = 1'b0;
    bit         xmit_en = 1'b1;
    bit         tmo_expected = 1'b0;
    int         tx_count = 0;
    logic [7:0] sent_data = 8'h00;
    vec_t       t1 [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Message-level round robin over the pending producer queues.
    task automatic plan();
        logic [8:0] cp [N][$];
        logic [8:0] head;
        bit more;
        for (int i = 0; i < N; i++) cp[i] = prod_q[i];
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (model_ptr + k) % N;
                if (!more && cp[c].size() > 0) begin
                    more = 1'b1;
                    do begin
                        head = cp[c].pop_front();
                        exp_q.push_back('{src: c, data: head[7:0]});
                    end while (!head[8] && cp[c].size() > 0);
                    model_ptr = c;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < budget && !(exp_q.size() == 0 && grant == '0 && !tx_busy));
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle_grant"}, 32'(grant), 32'd0);
    endtask

    task automatic wait_start(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < budget);
        check({name, "_tx_start_seen"}, 32'(tx_start), 32'd1);
    endtask

    task automatic wait_busy(input string name, input logic level, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (tx_busy !== level && n < budget);
        check({name, "_busy_level"}, 32'(tx_busy), 32'(level));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_grant"}, 32'(grant), 32'd0);
        check({name, "_req_ready"}, 32'(req_ready), 32'd0);
        check({name, "_tx_start"}, 32'(tx_start), 32'd0);
        check({name, "_tx_data"}, 32'(tx_data), 32'd0);
        check({name, "_err_tmo"}, 32'(err_tmo), 32'd0);
    endtask

    // Producers, transmitter model and per-cycle monitor, all at the falling edge.
    initial begin
        int         src;
        exp_t       e;
        logic [8:0] head;
        tx_busy   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            check("ready_eq_grant_gated", 32'(req_ready), 32'(grant & {N{tx_start}}));
            if (tx_busy && rst_n) check("tx_data_stable", 32'(tx_data), 32'(sent_data));
            if (err_tmo && !tmo_expected) begin
                checks++;
                failures++;
                $display("FAIL unexpected_err_tmo actual=1 required=0");
            end
            if (tx_start) begin
                src = -1;
                check("grant_onehot", 32'($onehot(grant)), 32'd1);
                for (int i = 0; i < N; i++) if (grant[i]) src = i;
                sent_data = tx_data;
                tx_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_tx_start src=%0d data=%0h required=none", src, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_src", 32'(src), 32'(e.src));
                    check("tx_byte", 32'(tx_data), 32'(e.data));
                end
                if (src >= 0 && prod_q[src].size() > 0) void'(prod_q[src].pop_front());
            end
            if (!rst_n) begin
                busy_cnt  = 0;
                start_d   = 1'b0;
                sent_data = 8'h00;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (start_d && xmit_en) busy_cnt = BUSY_LEN;
                start_d = tx_start;
            end
            tx_busy = (busy_cnt > 0);
            for (int i = 0; i < N; i++) begin
                if (prod_q[i].size() > 0) begin
                    head          = prod_q[i][0];
                    req_valid[i]  = 1'b1;
                    req_data[8*i +: 8] = head[7:0];
                    req_last[i]   = head[8];
                end else begin
                    req_valid[i]  = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]   = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int n;
        int nmsg;
        int len;
        rst_n = 1'b0;
        t1[0] = '{src: 3, data: 8'h43, exp_src: 0, exp_data: 8'h10};
        t1[1] = '{src: 0, data: 8'h10, exp_src: 1, exp_data: 8'h21};
        t1[2] = '{src: 2, data: 8'h32, exp_src: 2, exp_data: 8'h32};
        t1[3] = '{src: 1, data: 8'h21, exp_src: 3, exp_data: 8'h43};
        t1[4] = '{src: 0, data: 8'h11, exp_src: 0, exp_data: 8'h11};
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: all four single-byte requesters, grant order 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            prod_q[t1[i].src].push_back({1'b1, t1[i].data});
            exp_q.push_back('{src: t1[i].exp_src, data: t1[i].exp_data});
        end
        model_ptr = 0;
        wait_idle("t1", 400);

        // 2: three-byte message from req1 runs contiguously ahead of req2
        base = tx_count;
        prod_q[1].push_back({1'b0, 8'hA1});
        prod_q[1].push_back({1'b0, 8'hA2});
        prod_q[1].push_back({1'b1, 8'hA3});
        prod_q[2].push_back({1'b1, 8'hB2});
        plan();
        n = 0;
        do begin
            tick();
            n++;
        end while (grant !== 4'b0100 && n < 200);
        check("t2_grant_req2", 32'(grant), 32'h4);
        check("t2_bytes_before_req2", 32'(tx_count - base), 32'd3);
        wait_idle("t2", 200);

        // 3: transmitter never acknowledges; watchdog fires ACK_TMO cycles later
        xmit_en      = 1'b0;
        tmo_expected = 1'b1;
        prod_q[0].push_back({1'b1, 8'hE0});
        prod_q[1].push_back({1'b1, 8'hE1});
        plan();
        wait_start("t3", 60);
        n = 0;
        do begin
            tick();
            n++;
        end while (!err_tmo && n < 40);
        check("t3_tmo_delay", 32'(n), 32'(TMO));
        check("t3_err_tmo", 32'(err_tmo), 32'd1);
        check("t3_grant_released", 32'(grant), 32'd0);
        xmit_en = 1'b1;
        tick();
        check("t3_err_single_pulse", 32'(err_tmo), 32'd0);
        tmo_expected = 1'b0;
        wait_idle("t3", 200);

        // 4: owner abandons mid-message while in SEND
        prod_q[3].push_back({1'b0, 8'hD1});
        plan();
        wait_start("t4", 60);
        wait_busy("t4_rise", 1'b1, 20);
        wait_busy("t4_fall", 1'b0, 20);
        tick();
        check("t4_grant_in_send", 32'(grant), 32'h8);
        check("t4_no_start_in_send", 32'(tx_start), 32'd0);
        tick();
        check("t4_grant_dropped", 32'(grant), 32'd0);
        check("t4_no_start_after_drop", 32'(tx_start), 32'd0);
        check("t4_no_ready_after_drop", 32'(req_ready), 32'd0);
        wait_idle("t4a", 60);
        prod_q[3].push_back({1'b1, 8'hE3});
        prod_q[2].push_back({1'b1, 8'hE2});
        plan();
        wait_idle("t4b", 200);

        // 5: reset while the second byte of a message is being serialised
        prod_q[1].push_back({1'b0, 8'hC1});
        prod_q[1].push_back({1'b0, 8'hC2});
        prod_q[1].push_back({1'b1, 8'hC3});
        plan();
        wait_start("t5_b1", 60);
        wait_start("t5_b2", 60);
        wait_busy("t5_rise", 1'b1, 20);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("t5_reset");
        for (int i = 0; i < N; i++) prod_q[i].delete();
        exp_q.delete();
        tick();
        rst_n     = 1'b1;
        model_ptr = N - 1;
        tick();
        prod_q[3].push_back({1'b1, 8'hF3});
        prod_q[1].push_back({1'b1, 8'hF1});
        prod_q[0].push_back({1'b1, 8'hF0});
        plan();
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 20);
        check("t5_first_grant_req0", 32'(grant), 32'h1);
        wait_idle("t5", 300);

        // Random message mixes against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                nmsg = $urandom_range(0, 2);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        prod_q[i].push_back({(b == len - 1), 8'($urandom)});
                    end
                end
            end
            plan();
            wait_idle("rand", 3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
